// File: rtl/eth_pkg.sv
// Shared constants, state encoding and MAC byte helper for the Ethernet receive dispatcher.
package eth_pkg;

   localparam logic [15:0] ETYPE_IPV4  = 16'h0800;
   localparam logic [15:0] ETYPE_ARP   = 16'h0806;
   localparam logic [47:0] MAC_BCAST   = 48'hFFFF_FFFF_FFFF;
   localparam int          ETH_HDR_LEN = 14;

   typedef enum logic [2:0] {
      IDLE,
      DST,
      SRC,
      TYPE,
      PAYLOAD,
      DROP
   } dispatch_state_t;

   // Byte 0 of a MAC is the most significant octet, i.e. the first one on the wire.
   function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [3:0] idx);
      logic [7:0] b;
      b = 8'h00;
      case (idx)
         4'd0:    b = mac[47:40];
         4'd1:    b = mac[39:32];
         4'd2:    b = mac[31:24];
         4'd3:    b = mac[23:16];
         4'd4:    b = mac[15:8];
         4'd5:    b = mac[7:0];
         default: b = 8'h00;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/eth_rx_stats.sv
// Saturating frame statistics counters with synchronous clear; built only when
// ETH_RX_STATS_EN is defined.
`ifdef ETH_RX_STATS_EN
module eth_rx_stats #(
   parameter int pCNT_WIDTH = 16
) (
   input  logic                  Clk,
   input  logic                  Rst_n,
   input  logic                  Cnt_Clr,
   input  logic                  Inc_Accept,
   input  logic                  Inc_Drop,
   input  logic                  Inc_Runt,
   input  logic                  Inc_Trunc,
   output logic [pCNT_WIDTH-1:0] Cnt_Accept,
   output logic [pCNT_WIDTH-1:0] Cnt_Drop,
   output logic [pCNT_WIDTH-1:0] Cnt_Runt,
   output logic [pCNT_WIDTH-1:0] Cnt_Trunc
);

   logic [3:0]            inc;
   logic [pCNT_WIDTH-1:0] cnt_q [4];
   logic [pCNT_WIDTH-1:0] cnt_d [4];

   assign inc = {Inc_Trunc, Inc_Runt, Inc_Drop, Inc_Accept};

   // Clear has priority over any increment arriving in the same cycle.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         cnt_d[i] = cnt_q[i];
         if (Cnt_Clr) begin
            cnt_d[i] = '0;
         end else if (inc[i] && !(&cnt_q[i])) begin
            cnt_d[i] = cnt_q[i] + 1'b1;
         end
      end
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         for (int i = 0; i < 4; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 4; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   assign Cnt_Accept = cnt_q[0];
   assign Cnt_Drop   = cnt_q[1];
   assign Cnt_Runt   = cnt_q[2];
   assign Cnt_Trunc  = cnt_q[3];

endmodule
`endif

// File: rtl/eth_rx_dispatch.sv
// Splits the eth_rx byte stream into frames, filters on destination MAC and EtherType,
// and forwards the payload tagged IPv4/ARP. Statistics counters exist under ETH_RX_STATS_EN.
module eth_rx_dispatch
   import eth_pkg::*;
#(
   parameter int pMAX_PAYLOAD = 1500
`ifdef ETH_RX_STATS_EN
   ,
   parameter int pCNT_WIDTH   = 16
`endif
) (
   input  logic                  Clk,
   input  logic                  Rst_n,
   input  logic [7:0]            Rx_Data,
   input  logic                  Rx_Valid,
   input  logic                  Rx_Sop,
   input  logic                  Rx_Eop,
   input  logic [47:0]           Mac_Addr,
   input  logic                  Promisc,
`ifdef ETH_RX_STATS_EN
   input  logic                  Cnt_Clr,
   output logic [pCNT_WIDTH-1:0] Cnt_Accept,
   output logic [pCNT_WIDTH-1:0] Cnt_Drop,
   output logic [pCNT_WIDTH-1:0] Cnt_Runt,
   output logic [pCNT_WIDTH-1:0] Cnt_Trunc,
`endif
   output logic                  Hdr_Vld,
   output logic [47:0]           Hdr_Src_Mac,
   output logic [15:0]           Hdr_Type,
   output logic [7:0]            Pl_Data,
   output logic                  Pl_Valid,
   output logic                  Pl_Sel,
   output logic                  Pl_Last,
   output logic                  Pl_Err,
   output logic                  Pl_Abort
);

   localparam int CW = $clog2(pMAX_PAYLOAD + 1);

   dispatch_state_t state_q;
   logic [3:0]      idx_q;
   logic            ucast_miss_q;
   logic            bcast_miss_q;
   logic [47:0]     src_sh_q;
   logic [7:0]      type_hi_q;
   logic [CW-1:0]   pl_cnt_q;

   logic            hdr_vld_q;
   logic [47:0]     hdr_src_q;
   logic [15:0]     hdr_type_q;
   logic [7:0]      pl_data_q;
   logic            pl_valid_q;
   logic            pl_sel_q;
   logic            pl_last_q;
   logic            pl_err_q;
   logic            pl_abort_q;

   logic [15:0]     type_now;
   logic            hdr_last;
   logic            hdr_accept;

   // The MAC miss flags are final by byte 13, so the decision needs only the last type byte.
   assign type_now   = {type_hi_q, Rx_Data};
   assign hdr_last   = (idx_q == 4'(ETH_HDR_LEN - 1));
   assign hdr_accept = (!ucast_miss_q || !bcast_miss_q || Promisc) &&
                       ((type_now == ETYPE_IPV4) || (type_now == ETYPE_ARP));

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q      <= IDLE;
         idx_q        <= '0;
         ucast_miss_q <= 1'b0;
         bcast_miss_q <= 1'b0;
         src_sh_q     <= '0;
         type_hi_q    <= '0;
         pl_cnt_q     <= '0;
         hdr_vld_q    <= 1'b0;
         hdr_src_q    <= '0;
         hdr_type_q   <= '0;
         pl_data_q    <= '0;
         pl_valid_q   <= 1'b0;
         pl_sel_q     <= 1'b0;
         pl_last_q    <= 1'b0;
         pl_err_q     <= 1'b0;
         pl_abort_q   <= 1'b0;
      end else begin
         hdr_vld_q  <= 1'b0;
         pl_valid_q <= 1'b0;
         pl_last_q  <= 1'b0;
         pl_err_q   <= 1'b0;
         pl_abort_q <= 1'b0;
         if (Rx_Valid && Rx_Sop) begin
            // A start-of-frame always abandons whatever was in progress.
            if (state_q == PAYLOAD) begin
               pl_abort_q <= 1'b1;
            end
            if ((state_q == IDLE) && Rx_Eop) begin
               state_q <= IDLE;
            end else begin
               state_q      <= DST;
               idx_q        <= 4'd1;
               ucast_miss_q <= (Rx_Data != mac_byte(Mac_Addr, 4'd0));
               bcast_miss_q <= (Rx_Data != mac_byte(MAC_BCAST, 4'd0));
               pl_cnt_q     <= '0;
            end
         end else if (Rx_Valid) begin
            case (state_q)
               DST: begin
                  ucast_miss_q <= ucast_miss_q | (Rx_Data != mac_byte(Mac_Addr, idx_q));
                  bcast_miss_q <= bcast_miss_q | (Rx_Data != mac_byte(MAC_BCAST, idx_q));
                  idx_q        <= idx_q + 4'd1;
                  if (Rx_Eop) begin
                     state_q <= IDLE;
                  end else if (idx_q == 4'd5) begin
                     state_q <= SRC;
                  end
               end
               SRC: begin
                  src_sh_q <= {src_sh_q[39:0], Rx_Data};
                  idx_q    <= idx_q + 4'd1;
                  if (Rx_Eop) begin
                     state_q <= IDLE;
                  end else if (idx_q == 4'd11) begin
                     state_q <= TYPE;
                  end
               end
               TYPE: begin
                  type_hi_q <= Rx_Data;
                  idx_q     <= idx_q + 4'd1;
                  if (Rx_Eop) begin
                     state_q <= IDLE;
                  end else if (hdr_last) begin
                     if (hdr_accept) begin
                        state_q    <= PAYLOAD;
                        hdr_vld_q  <= 1'b1;
                        hdr_src_q  <= src_sh_q;
                        hdr_type_q <= type_now;
                        pl_sel_q   <= (type_now == ETYPE_ARP);
                     end else begin
                        state_q <= DROP;
                     end
                  end
               end
               PAYLOAD: begin
                  pl_data_q  <= Rx_Data;
                  pl_valid_q <= 1'b1;
                  if (pl_cnt_q != CW'(pMAX_PAYLOAD)) begin
                     pl_cnt_q <= pl_cnt_q + 1'b1;
                  end
                  if (Rx_Eop) begin
                     pl_last_q <= 1'b1;
                     state_q   <= IDLE;
                  end else if (pl_cnt_q == CW'(pMAX_PAYLOAD - 1)) begin
                     pl_last_q <= 1'b1;
                     pl_err_q  <= 1'b1;
                     state_q   <= DROP;
                  end
               end
               DROP: begin
                  if (Rx_Eop) begin
                     state_q <= IDLE;
                  end
               end
               default: begin
                  state_q <= IDLE;
               end
            endcase
         end
      end
   end

   assign Hdr_Vld     = hdr_vld_q;
   assign Hdr_Src_Mac = hdr_src_q;
   assign Hdr_Type    = hdr_type_q;
   assign Pl_Data     = pl_data_q;
   assign Pl_Valid    = pl_valid_q;
   assign Pl_Sel      = pl_sel_q;
   assign Pl_Last     = pl_last_q;
   assign Pl_Err      = pl_err_q;
   assign Pl_Abort    = pl_abort_q;

`ifdef ETH_RX_STATS_EN
   logic runt_ev;
   logic drop_ev;

   // Runts and rejects are visible on the incoming byte; accept/trunc reuse the output pulses.
   always_comb begin
      runt_ev = 1'b0;
      drop_ev = 1'b0;
      if (Rx_Valid) begin
         if (Rx_Sop) begin
            runt_ev = (state_q == IDLE) && Rx_Eop;
            drop_ev = (state_q == PAYLOAD);
         end else if (Rx_Eop && ((state_q == DST) || (state_q == SRC) || (state_q == TYPE))) begin
            runt_ev = 1'b1;
         end else if ((state_q == TYPE) && hdr_last && !hdr_accept) begin
            drop_ev = 1'b1;
         end
      end
   end

   eth_rx_stats #(
      .pCNT_WIDTH (pCNT_WIDTH)
   ) u_stats (
      .Clk        (Clk),
      .Rst_n      (Rst_n),
      .Cnt_Clr    (Cnt_Clr),
      .Inc_Accept (hdr_vld_q),
      .Inc_Drop   (drop_ev),
      .Inc_Runt   (runt_ev),
      .Inc_Trunc  (pl_err_q),
      .Cnt_Accept (Cnt_Accept),
      .Cnt_Drop   (Cnt_Drop),
      .Cnt_Runt   (Cnt_Runt),
      .Cnt_Trunc  (Cnt_Trunc)
   );
`endif

endmodule

// File: tb/tb_eth_rx_dispatch.sv
// Directed frame-table bench for eth_rx_dispatch, plus hand-written abort, runt and
// reset sequences; statistics checks only when ETH_RX_STATS_EN is defined.
module tb_eth_rx_dispatch;

   localparam int MAXP = 64;

   logic        Clk;
   logic        Rst_n;
   logic [7:0]  Rx_Data;
   logic        Rx_Valid;
   logic        Rx_Sop;
   logic        Rx_Eop;
   logic [47:0] Mac_Addr;
   logic        Promisc;
   logic        Hdr_Vld;
   logic [47:0] Hdr_Src_Mac;
   logic [15:0] Hdr_Type;
   logic [7:0]  Pl_Data;
   logic        Pl_Valid;
   logic        Pl_Sel;
   logic        Pl_Last;
   logic        Pl_Err;
   logic        Pl_Abort;
`ifdef ETH_RX_STATS_EN
   logic        Cnt_Clr;
   logic [15:0] Cnt_Accept;
   logic [15:0] Cnt_Drop;
   logic [15:0] Cnt_Runt;
   logic [15:0] Cnt_Trunc;
`endif

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [47:0] dst;
      logic [47:0] src;
      logic [15:0] etype;
      int          len;
      logic        promisc;
      int          gap;
      logic        expAccept;
   } frame_t;

   frame_t vec[10];

   eth_rx_dispatch #(
      .pMAX_PAYLOAD (MAXP)
   ) dut (
      .Clk         (Clk),
      .Rst_n       (Rst_n),
      .Rx_Data     (Rx_Data),
      .Rx_Valid    (Rx_Valid),
      .Rx_Sop      (Rx_Sop),
      .Rx_Eop      (Rx_Eop),
      .Mac_Addr    (Mac_Addr),
      .Promisc     (Promisc),
`ifdef ETH_RX_STATS_EN
      .Cnt_Clr     (Cnt_Clr),
      .Cnt_Accept  (Cnt_Accept),
      .Cnt_Drop    (Cnt_Drop),
      .Cnt_Runt    (Cnt_Runt),
      .Cnt_Trunc   (Cnt_Trunc),
`endif
      .Hdr_Vld     (Hdr_Vld),
      .Hdr_Src_Mac (Hdr_Src_Mac),
      .Hdr_Type    (Hdr_Type),
      .Pl_Data     (Pl_Data),
      .Pl_Valid    (Pl_Valid),
      .Pl_Sel      (Pl_Sel),
      .Pl_Last     (Pl_Last),
      .Pl_Err      (Pl_Err),
      .Pl_Abort    (Pl_Abort)
   );

   // Free-running 100 MHz clock.
   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   // Wire order of a frame: destination, source, EtherType, then a fixed payload pattern.
   function automatic logic [7:0] frameByte(input frame_t f, input int i);
      logic [7:0] b;
      if (i < 6)       b = f.dst[8*(5-i) +: 8];
      else if (i < 12) b = f.src[8*(11-i) +: 8];
      else if (i < 14) b = f.etype[8*(13-i) +: 8];
      else             b = 8'((i * 7 + 3) & 255);
      return b;
   endfunction

   function automatic logic [13:0] actVec();
      return {Hdr_Vld, Pl_Valid, Pl_Last, Pl_Err, Pl_Abort,
              (Pl_Valid ? {Pl_Sel, Pl_Data} : 9'h0)};
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic idleCycles(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge Clk);
         #1;
         checkOutput("idle", 64'(actVec()), 64'h0);
      end
   endtask

   // Sends the first nBytes of frame f and checks every output cycle against the expected stream.
   task automatic applyStimulus(input frame_t f, input int nBytes, input bit expAbort);
      int          p;
      logic        v, l, e;
      logic [13:0] exp;
      Promisc = f.promisc;
      for (int i = 0; i < nBytes; i++) begin
         Rx_Valid = 1'b1;
         Rx_Data  = frameByte(f, i);
         Rx_Sop   = (i == 0);
         Rx_Eop   = (i == f.len - 1);
         @(posedge Clk);
         #1;
         Rx_Valid = 1'b0;
         Rx_Sop   = 1'b0;
         Rx_Eop   = 1'b0;
         p = i - 14;
         v = f.expAccept && (p >= 0) && (p < MAXP);
         l = v && ((i == f.len - 1) || (p == MAXP - 1));
         e = v && (p == MAXP - 1) && (i != f.len - 1);
         exp = {(f.expAccept && (i == 13)), v, l, e, (expAbort && (i == 0)),
                (v ? {(f.etype == 16'h0806), frameByte(f, i)} : 9'h0)};
         checkOutput($sformatf("byte%0d", i), 64'(actVec()), 64'(exp));
         for (int g = 0; g < f.gap; g++) begin
            @(posedge Clk);
            #1;
            checkOutput("gap", 64'(actVec()), 64'h0);
         end
      end
      if (f.expAccept && (nBytes > 13)) begin
         checkOutput("hdr_src_mac", 64'(Hdr_Src_Mac), 64'(f.src));
         checkOutput("hdr_type", 64'(Hdr_Type), 64'(f.etype));
      end
   endtask

   initial begin
      vec[0] = '{dst: 48'h020000000001, src: 48'h0A1122334455, etype: 16'h0800, len: 60,  promisc: 1'b0, gap: 0, expAccept: 1'b1};
      vec[1] = '{dst: 48'hFFFFFFFFFFFF, src: 48'h0A0B0C0D0E0F, etype: 16'h0806, len: 42,  promisc: 1'b0, gap: 3, expAccept: 1'b1};
      vec[2] = '{dst: 48'h020000000002, src: 48'h0A0000000002, etype: 16'h0800, len: 60,  promisc: 1'b0, gap: 0, expAccept: 1'b0};
      vec[3] = '{dst: 48'h020000000002, src: 48'h0A0000000002, etype: 16'h0800, len: 60,  promisc: 1'b1, gap: 0, expAccept: 1'b1};
      vec[4] = '{dst: 48'h020000000001, src: 48'h0A0000000004, etype: 16'h86DD, len: 60,  promisc: 1'b0, gap: 0, expAccept: 1'b0};
      vec[5] = '{dst: 48'h020000000001, src: 48'h0A0000000005, etype: 16'h0800, len: 10,  promisc: 1'b0, gap: 0, expAccept: 1'b0};
      vec[6] = '{dst: 48'h020000000001, src: 48'h0A0000000006, etype: 16'h0800, len: 114, promisc: 1'b0, gap: 0, expAccept: 1'b1};
      vec[7] = '{dst: 48'h020000000001, src: 48'h0A0000000007, etype: 16'h0800, len: 14,  promisc: 1'b0, gap: 0, expAccept: 1'b0};
      vec[8] = '{dst: 48'h020000000001, src: 48'h0A0000000008, etype: 16'h0806, len: 78,  promisc: 1'b0, gap: 0, expAccept: 1'b1};
      vec[9] = '{dst: 48'h020000010001, src: 48'h0A0000000009, etype: 16'h0800, len: 60,  promisc: 1'b0, gap: 0, expAccept: 1'b0};

      Rst_n    = 1'b0;
      Rx_Data  = 8'h00;
      Rx_Valid = 1'b0;
      Rx_Sop   = 1'b0;
      Rx_Eop   = 1'b0;
      Promisc  = 1'b0;
      Mac_Addr = 48'h020000000001;
`ifdef ETH_RX_STATS_EN
      Cnt_Clr  = 1'b0;
`endif
      repeat (3) @(posedge Clk);
      #1;
      checkOutput("reset_pulses", 64'(actVec()), 64'h0);
      checkOutput("reset_src", 64'(Hdr_Src_Mac), 64'h0);
      checkOutput("reset_type_sel_data", 64'({Hdr_Type, Pl_Sel, Pl_Data}), 64'h0);
      @(negedge Clk);
      Rst_n = 1'b1;
      @(posedge Clk);
      #1;

      for (int n = 0; n < 10; n++) begin
         applyStimulus(vec[n], vec[n].len, 1'b0);
         idleCycles(2);
      end

      // One-byte frame (Sop and Eop together) must leave the parser idle for the stray bytes.
      Rx_Valid = 1'b1;
      Rx_Sop   = 1'b1;
      Rx_Eop   = 1'b1;
      Rx_Data  = frameByte(vec[0], 0);
      @(posedge Clk);
      #1;
      Rx_Sop = 1'b0;
      Rx_Eop = 1'b0;
      checkOutput("runt1_sop_eop", 64'(actVec()), 64'h0);
      for (int i = 1; i < vec[0].len; i++) begin
         Rx_Valid = 1'b1;
         Rx_Data  = frameByte(vec[0], i);
         Rx_Eop   = (i == vec[0].len - 1);
         @(posedge Clk);
         #1;
         Rx_Valid = 1'b0;
         Rx_Eop   = 1'b0;
         checkOutput("stray_after_runt", 64'(actVec()), 64'h0);
      end
      idleCycles(2);

      // New Sop at payload byte 20 aborts the forwarded frame and starts parsing the next one.
      applyStimulus(vec[0], 34, 1'b0);
      applyStimulus(vec[1], vec[1].len, 1'b1);
      idleCycles(2);

`ifdef ETH_RX_STATS_EN
      checkOutput("cnt_accept", 64'(Cnt_Accept), 64'd7);
      checkOutput("cnt_drop", 64'(Cnt_Drop), 64'd4);
      checkOutput("cnt_runt", 64'(Cnt_Runt), 64'd3);
      checkOutput("cnt_trunc", 64'(Cnt_Trunc), 64'd1);
      Cnt_Clr = 1'b1;
      @(posedge Clk);
      #1;
      Cnt_Clr = 1'b0;
      checkOutput("cnt_clear", 64'({Cnt_Accept, Cnt_Drop, Cnt_Runt, Cnt_Trunc}), 64'h0);
`endif

      // Reset in the middle of a header clears outputs at once; following bytes lack Sop.
      applyStimulus(vec[0], 8, 1'b0);
      Rst_n = 1'b0;
      #2;
      checkOutput("midreset_src", 64'(Hdr_Src_Mac), 64'h0);
      checkOutput("midreset_type", 64'(Hdr_Type), 64'h0);
      checkOutput("midreset_pulses", 64'(actVec()), 64'h0);
      @(negedge Clk);
      Rst_n = 1'b1;
      @(posedge Clk);
      #1;
      for (int i = 8; i < vec[0].len; i++) begin
         Rx_Valid = 1'b1;
         Rx_Data  = frameByte(vec[0], i);
         Rx_Eop   = (i == vec[0].len - 1);
         @(posedge Clk);
         #1;
         Rx_Valid = 1'b0;
         Rx_Eop   = 1'b0;
         checkOutput("post_reset_stray", 64'(actVec()), 64'h0);
      end
      applyStimulus(vec[0], vec[0].len, 1'b0);
      idleCycles(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
